// File: rtl/pr_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pr_seq_pkg
// Description : Shared types, error codes and conduit bit-field offsets for
//               the partial-reconfiguration region sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pr_seq_pkg;

  // Number of PR regions served by one conduit
  localparam int NUM_REGIONS = 4;

  // ctrl_out (conduit out_port) field offsets, one bit per region
  localparam int FRZ_LSB   = 0;   // freeze_req
  localparam int RST_LSB   = 4;   // region reset
  localparam int UNFRZ_LSB = 8;   // unfreeze_req

  // ctrl_in (conduit in_port) field offsets
  localparam int USTAT_LSB = 0;   // unfreeze_status, one bit per region
  localparam int FSTAT_LSB = 4;   // freeze_status, one bit per region
  localparam int ILL_LSB   = 8;   // illegal_req, two bits per region

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FRZ   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_UNFRZ = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } pr_state_e;

  // Error codes reported on err_code
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL = 2'd2;
  localparam logic [1:0] ERR_LOAD    = 2'd3;

  // One-hot mask selecting a single region's bit within a request field
  function automatic logic [NUM_REGIONS-1:0] region_onehot(input logic [1:0] region);
    logic [NUM_REGIONS-1:0] mask;
    mask         = '0;
    mask[region] = 1'b1;
    return mask;
  endfunction

  // Larger of two integers, used to size the shared step timer
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pr_seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : pr_seq_timer
// Description : Step timer for the PR sequencer. Clear has priority over
//               enable; tc flags when the count equals the supplied terminal
//               value. The owner always leaves the state on tc, so the
//               counter never needs to wrap or saturate.
// Revision    : 1.0 - initial release
// ============================================================================
module pr_seq_timer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] tc_value,
  output logic             tc
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear wins, otherwise count while enabled
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == tc_value);

endmodule
`default_nettype wire

// File: rtl/pr_region_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pr_region_sequencer
// Description : Hardware PR sequencer for the 16-bit PR control conduit.
//               Runs freeze -> region reset -> bitstream load -> unfreeze ->
//               reset release for one of four regions, with a per-step
//               timeout, illegal-request abort and sticky reset on error.
// Revision    : 1.0 - initial release
// ============================================================================
module pr_region_sequencer
  import pr_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int RST_HOLD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_region,
  output logic        pr_load_req,
  input  logic        pr_load_done,
  input  logic        pr_load_error,
  output logic [15:0] ctrl_out,
  input  logic [15:0] ctrl_in,
  output logic        busy,
  output logic        done,
  output logic        err_valid,
  output logic [1:0]  err_code
);

  // One timer serves both the wait-state timeout and the reset hold count
  localparam int TIMER_W = $clog2(max_int(TIMEOUT_CYCLES, RST_HOLD_CYCLES));
  localparam logic [TIMER_W-1:0] TIMEOUT_TC = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HOLD_TC    = TIMER_W'(RST_HOLD_CYCLES - 1);

  // Sequencer state
  pr_state_e              state_q, state_d;
  logic [1:0]             region_q, region_d;
  logic [NUM_REGIONS-1:0] sticky_rst_q, sticky_rst_d;
  logic [1:0]             err_code_q, err_code_d;

  // Registered outputs
  logic [15:0]            ctrl_out_q, ctrl_out_d;
  logic                   pr_load_req_q, pr_load_req_d;
  logic                   done_q, done_d;
  logic                   err_valid_q, err_valid_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   busy_q, busy_d;

  // Decoded status for the latched region
  logic                   accept;
  logic                   illegal;
  logic                   freeze_ack;
  logic                   unfreeze_ack;
  logic [1:0]             illegal_bits;

  // Step timer interface
  logic                   timer_clear;
  logic                   timer_en;
  logic                   timer_tc;
  logic [TIMER_W-1:0]     timer_tc_value;

  // Error entry bookkeeping inside the next-state logic
  logic                   err_entry;
  logic [1:0]             err_sel;

  // Output decode helpers
  logic [NUM_REGIONS-1:0] region_mask_d;

  assign accept       = cmd_valid & cmd_ready_q;
  assign illegal_bits = ctrl_in[ILL_LSB + 2*int'(region_q) +: 2];
  assign illegal      = |illegal_bits;
  assign freeze_ack   = ctrl_in[FSTAT_LSB + int'(region_q)];
  assign unfreeze_ack = ctrl_in[USTAT_LSB + int'(region_q)];

  // Timer restarts on every state change; it runs in the wait states and in HOLD
  assign timer_clear    = (state_d != state_q);
  assign timer_en       = (state_q == ST_FRZ)   || (state_q == ST_LOAD) ||
                          (state_q == ST_UNFRZ) || (state_q == ST_HOLD);
  assign timer_tc_value = (state_q == ST_HOLD) ? HOLD_TC : TIMEOUT_TC;

  pr_seq_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (timer_clear),
    .enable   (timer_en),
    .tc_value (timer_tc_value),
    .tc       (timer_tc)
  );

  // Next-state logic: illegal beats completion beats timeout; load error beats load done
  always_comb begin
    state_d      = state_q;
    region_d     = region_q;
    sticky_rst_d = sticky_rst_q;
    err_code_d   = err_code_q;
    err_entry    = 1'b0;
    err_sel      = ERR_NONE;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          region_d   = cmd_region;
          err_code_d = ERR_NONE;
          state_d    = ST_FRZ;
        end
      end
      ST_FRZ: begin
        if (illegal) begin
          err_entry = 1'b1;
          err_sel   = ERR_ILLEGAL;
        end else if (freeze_ack) begin
          state_d = ST_LOAD;
        end else if (timer_tc) begin
          err_entry = 1'b1;
          err_sel   = ERR_TIMEOUT;
        end
      end
      ST_LOAD: begin
        if (illegal) begin
          err_entry = 1'b1;
          err_sel   = ERR_ILLEGAL;
        end else if (pr_load_error) begin
          err_entry = 1'b1;
          err_sel   = ERR_LOAD;
        end else if (pr_load_done) begin
          state_d = ST_UNFRZ;
        end else if (timer_tc) begin
          err_entry = 1'b1;
          err_sel   = ERR_TIMEOUT;
        end
      end
      ST_UNFRZ: begin
        if (illegal) begin
          err_entry = 1'b1;
          err_sel   = ERR_ILLEGAL;
        end else if (unfreeze_ack) begin
          state_d = ST_HOLD;
        end else if (timer_tc) begin
          err_entry = 1'b1;
          err_sel   = ERR_TIMEOUT;
        end
      end
      ST_HOLD: begin
        if (illegal) begin
          err_entry = 1'b1;
          err_sel   = ERR_ILLEGAL;
        end else if (timer_tc) begin
          // Successful completion releases any reset left behind by an earlier error
          state_d      = ST_DONE;
          sticky_rst_d = sticky_rst_q & ~region_onehot(region_q);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A failed region is left held in reset until a later successful run
    if (err_entry) begin
      state_d      = ST_ERR;
      err_code_d   = err_sel;
      sticky_rst_d = sticky_rst_q | region_onehot(region_q);
    end
  end

  // Output decode from the next state so every output is a plain register
  always_comb begin
    region_mask_d = region_onehot(region_d);
    ctrl_out_d    = '0;
    pr_load_req_d = 1'b0;
    ctrl_out_d[RST_LSB +: NUM_REGIONS] = sticky_rst_d;

    case (state_d)
      ST_FRZ: begin
        ctrl_out_d[FRZ_LSB +: NUM_REGIONS] = region_mask_d;
      end
      ST_LOAD: begin
        ctrl_out_d[RST_LSB +: NUM_REGIONS] = sticky_rst_d | region_mask_d;
        pr_load_req_d = 1'b1;
      end
      ST_UNFRZ: begin
        ctrl_out_d[RST_LSB +: NUM_REGIONS]   = sticky_rst_d | region_mask_d;
        ctrl_out_d[UNFRZ_LSB +: NUM_REGIONS] = region_mask_d;
      end
      ST_HOLD: begin
        ctrl_out_d[RST_LSB +: NUM_REGIONS] = sticky_rst_d | region_mask_d;
      end
      default: begin
        ctrl_out_d[RST_LSB +: NUM_REGIONS] = sticky_rst_d;
      end
    endcase

    done_d      = (state_d == ST_DONE);
    err_valid_d = (state_d == ST_ERR);
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers; async reset returns everything, sticky included, to idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      region_q      <= 2'd0;
      sticky_rst_q  <= '0;
      err_code_q    <= ERR_NONE;
      ctrl_out_q    <= '0;
      pr_load_req_q <= 1'b0;
      done_q        <= 1'b0;
      err_valid_q   <= 1'b0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      region_q      <= region_d;
      sticky_rst_q  <= sticky_rst_d;
      err_code_q    <= err_code_d;
      ctrl_out_q    <= ctrl_out_d;
      pr_load_req_q <= pr_load_req_d;
      done_q        <= done_d;
      err_valid_q   <= err_valid_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_valid   = err_valid_q;
  assign err_code    = err_code_q;
  assign ctrl_out    = ctrl_out_q;
  assign pr_load_req = pr_load_req_q;

endmodule
`default_nettype wire

// File: tb/tb_pr_region_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pr_region_sequencer
// Description : Self-checking bench for pr_region_sequencer. Each command is
//               planned as a list of phases whose lengths follow from the
//               acknowledge delays, timeout and hold length; the plan yields
//               the expected per-cycle outputs and the stimulus timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pr_region_sequencer;

  localparam int TIMEOUT = 1024;
  localparam int HOLD    = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_region;
  logic        pr_load_req;
  logic        pr_load_done;
  logic        pr_load_error;
  logic [15:0] ctrl_out;
  logic [15:0] ctrl_in;
  logic        busy;
  logic        done;
  logic        err_valid;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  pr_region_sequencer #(
    .TIMEOUT_CYCLES  (TIMEOUT),
    .RST_HOLD_CYCLES (HOLD)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_region    (cmd_region),
    .pr_load_req   (pr_load_req),
    .pr_load_done  (pr_load_done),
    .pr_load_error (pr_load_error),
    .ctrl_out      (ctrl_out),
    .ctrl_in       (ctrl_in),
    .busy          (busy),
    .done          (done),
    .err_valid     (err_valid),
    .err_code      (err_code)
  );

  int checks = 0;
  int errors = 0;

  // Single comparison point for the whole bench
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Output word: {cmd_ready, busy, done, err_valid, err_code, pr_load_req, ctrl_out}
  function automatic logic [22:0] mkword(input bit rdy, input bit bsy, input bit dn, input bit ev,
                                         input logic [1:0] code, input bit lr, input logic [15:0] ctrl);
    return {rdy, bsy, dn, ev, code, lr, ctrl};
  endfunction

  function automatic logic [22:0] obs();
    return {cmd_ready, busy, done, err_valid, err_code, pr_load_req, ctrl_out};
  endfunction

  // Reference model state
  logic [22:0] exp_q[$];
  logic [3:0]  sticky_m;
  logic [1:0]  code_m;
  int          frz_ack, load_at, unfrz_ack, ill_at, seq_len, cur_r, run_id;
  int          ph_start[4];
  bit          load_err;
  logic [1:0]  ill_val;

  function automatic logic [22:0] idle_word();
    return mkword(1, 0, 0, 0, code_m, 0, {8'h00, sticky_m, 4'h0});
  endfunction

  // Expected outputs while in phase ph (0 freeze, 1 load, 2 unfreeze, 3 hold)
  function automatic logic [22:0] phase_word(input int ph, input logic [3:0] oh);
    case (ph)
      0:       return mkword(0, 1, 0, 0, 2'd0, 0, {8'h00, sticky_m, oh});
      1:       return mkword(0, 1, 0, 0, 2'd0, 1, {8'h00, sticky_m | oh, 4'h0});
      2:       return mkword(0, 1, 0, 0, 2'd0, 0, {4'h0, oh, sticky_m | oh, 4'h0});
      default: return mkword(0, 1, 0, 0, 2'd0, 0, {8'h00, sticky_m | oh, 4'h0});
    endcase
  endfunction

  // Plan one command. Delays are relative to phase start; negative means never.
  task automatic plan(input int r, input int fd, input int ld, input bit le, input int ud,
                      input int ill_ph, input int ill_rel);
    logic [3:0] oh;
    int t, ex, rel, ack_abs, outcome;
    bit ended;
    oh = 4'b0001 << r;
    exp_q.delete();
    frz_ack = -1; load_at = -1; unfrz_ack = -1; ill_at = -1;
    load_err = le; cur_r = r;
    for (int i = 0; i < 4; i++) ph_start[i] = -1;
    code_m = 2'd0;
    t = 0; ended = 0; outcome = 0;
    for (int ph = 0; ph < 4; ph++) begin
      if (!ended) begin
        ph_start[ph] = t;
        rel = (ph == 0) ? fd : (ph == 1) ? ld : (ph == 2) ? ud : -1;
        if (ph == 3) begin
          ex = t + HOLD - 1; ack_abs = -1; outcome = 0;
        end else if (rel >= 0 && rel <= TIMEOUT - 1) begin
          ex = t + rel; ack_abs = ex; outcome = (ph == 1 && le) ? 3 : 0;
        end else begin
          ex = t + TIMEOUT - 1; ack_abs = -1; outcome = 1;
        end
        if (ill_ph == ph && t + ill_rel <= ex) begin
          ex = t + ill_rel; ill_at = ex; outcome = 2;
          if (ack_abs > ex) ack_abs = -1;
        end
        if (ph == 0) frz_ack = ack_abs;
        else if (ph == 1) load_at = ack_abs;
        else if (ph == 2) unfrz_ack = ack_abs;
        for (int c = t; c <= ex; c++) exp_q.push_back(phase_word(ph, oh));
        t = ex + 1;
        if (outcome != 0) begin
          ended = 1;
          sticky_m = sticky_m | oh;
          code_m = 2'(outcome);
          exp_q.push_back(mkword(0, 1, 0, 1, code_m, 0, {8'h00, sticky_m, 4'h0}));
        end
      end
    end
    if (!ended) begin
      sticky_m = sticky_m & ~oh;
      exp_q.push_back(mkword(0, 1, 1, 0, 2'd0, 0, {8'h00, sticky_m, 4'h0}));
    end
    seq_len = exp_q.size();
  endtask

  // Conduit inputs for sequence cycle c; other regions carry random noise
  task automatic drive_cycle(input int c);
    logic [15:0] ci;
    int r;
    r  = cur_r;
    ci = 16'($urandom);
    ci[r] = 1'b0;
    ci[4 + r] = 1'b0;
    ci[8 + 2*r +: 2] = 2'b00;
    if (frz_ack >= 0 && c >= frz_ack) ci[4 + r] = 1'b1;
    if (unfrz_ack >= 0 && c >= unfrz_ack) ci[r] = 1'b1;
    if (c == ill_at) ci[8 + 2*r +: 2] = ill_val;
    ctrl_in       = ci;
    pr_load_done  = (c == load_at);
    pr_load_error = (c == load_at) && load_err;
  endtask

  // Idle cycles: entered and left 1 time unit after a rising edge
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("idle_after_run%0d", run_id), 32'(obs()), 32'(idle_word()));
      ctrl_in = 16'($urandom); pr_load_done = 1'b0; pr_load_error = 1'b0; cmd_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Issue one command and check every cycle against the plan
  task automatic do_run(input int r, input int fd, input int ld, input bit le, input int ud,
                        input int ill_ph, input int ill_rel, input logic [1:0] iv,
                        input bit hold_valid, input bit abort_unfrz);
    int abort_at;
    run_id++;
    chk($sformatf("run%0d_ready_before_cmd", run_id), 32'(obs()), 32'(idle_word()));
    plan(r, fd, ld, le, ud, ill_ph, ill_rel);
    ill_val = iv;
    abort_at = (abort_unfrz && ph_start[2] >= 0) ? ph_start[2] + 2 : -1;
    cmd_valid = 1'b1; cmd_region = 2'(r);
    ctrl_in = 16'($urandom); pr_load_done = 1'b0; pr_load_error = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < seq_len; c++) begin
      chk($sformatf("run%0d_r%0d_cyc%0d", run_id, r, c), 32'(obs()), 32'(exp_q[c]));
      drive_cycle(c);
      cmd_valid  = hold_valid;
      cmd_region = 2'($urandom);
      if (c == abort_at) begin
        #2 reset_n = 1'b0;
        #1 chk("async_reset_outputs", 32'(obs()), 32'(mkword(1, 0, 0, 0, 2'd0, 0, 16'h0000)));
        cmd_valid = 1'b0;
        sticky_m = 4'h0; code_m = 2'd0;
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_region = 2'd0;
    pr_load_done = 1'b0; pr_load_error = 1'b0; ctrl_in = 16'h0000;
    sticky_m = 4'h0; code_m = 2'd0; run_id = 0;
    repeat (2) @(posedge clk);
    #1 chk("reset_state", 32'(obs()), 32'(mkword(1, 0, 0, 0, 2'd0, 0, 16'h0000)));
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    idle_cycles(2);

    // Region 2 happy path
    do_run(2, 3, 10, 0, 3, -1, 0, 2'b00, 0, 0);
    idle_cycles(1);

    // Region 0 freeze timeout, then a clean run clears its sticky reset
    do_run(0, -1, 0, 0, 0, -1, 0, 2'b00, 0, 0);
    chk("timeout_ctrl_out", 32'(ctrl_out), 32'h0000_0010);
    chk("timeout_err_code", 32'(err_code), 32'd1);
    do_run(0, 1, 2, 0, 1, -1, 0, 2'b00, 0, 0);
    chk("sticky_bit4_cleared", 32'(ctrl_out[4]), 32'd0);

    // Region 3 illegal request together with load done
    do_run(3, 2, 5, 0, 2, 1, 5, 2'b01, 0, 0);
    chk("illegal_err_code", 32'(err_code), 32'd2);
    chk("illegal_sticky_rst7", 32'(ctrl_out[7]), 32'd1);

    // Region 1 load error together with load done
    do_run(1, 1, 4, 1, 2, -1, 0, 2'b00, 0, 0);
    chk("load_err_code", 32'(err_code), 32'd3);

    // Command held valid while busy
    do_run(1, 2, 3, 0, 2, -1, 0, 2'b00, 1, 0);
    chk("ready_after_done", 32'(cmd_ready), 32'd1);

    // Async reset while waiting for unfreeze, then a clean run
    do_run(2, 2, 3, 0, -1, -1, 0, 2'b00, 0, 1);
    do_run(2, 0, 0, 0, 0, -1, 0, 2'b00, 0, 0);

    // Randomized commands
    for (int n = 0; n < 25; n++) begin
      int r, fd, ld, ud, iph, irel;
      bit le, hv;
      logic [1:0] iv;
      r    = int'($urandom_range(0, 3));
      fd   = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 12));
      ld   = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 12));
      le   = ($urandom_range(0, 5) == 0);
      ud   = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 12));
      iph  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      irel = int'($urandom_range(0, 15));
      iv   = 2'($urandom_range(1, 3));
      hv   = $urandom_range(0, 1) == 1;
      do_run(r, fd, ld, le, ud, iph, irel, iv, hv, 0);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    idle_cycles(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
